// File: rtl/vadd_float_pkg.sv
// Shared defaults and helpers for the vadd_float operand-join path.
package vadd_float_pkg;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH  = 4;

  // Ceiling log2, usable in constant expressions for pointer widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/vadd_float_fifo.sv
// First-word-fall-through buffer; a pushed entry is at the head 1 cycle later.
// Backpressure: in_rdy is low when full or in reset, from registered occupancy only.
module vadd_float_fifo
  import vadd_float_pkg::*;
#(
  parameter int WIDTH = DEF_TDATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             ap_aclk,
  input  logic             ap_areset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // A pop in the same cycle never frees a slot for a push when full.
  assign in_rdy  = ~ap_areset & (count < FULL_CNT);
  assign out_vld = ~ap_areset & (count != '0);
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge ap_aclk) begin
    if (ap_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ap_aclk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

endmodule

// File: rtl/vadd_float_join.sv
// Pairs operand streams A and B into one {B,A} beat for vadd_float_adder; latency 1 cycle.
// Backpressure: each input buffers independently; both heads pop together on the output handshake.
module vadd_float_join
  import vadd_float_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int C_FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic                            ap_aclk,
  input  logic                            ap_areset,
  input  logic                            s_axis_a_tvalid,
  output logic                            s_axis_a_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_a_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_a_tkeep,
  input  logic                            s_axis_a_tlast,
  input  logic                            s_axis_b_tvalid,
  output logic                            s_axis_b_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_b_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_b_tkeep,
  input  logic                            s_axis_b_tlast,
  output logic                            m_axis_ab_tvalid,
  input  logic                            m_axis_ab_tready,
  output logic [2*C_AXIS_TDATA_WIDTH-1:0] m_axis_ab_tdata,
  output logic [C_AXIS_TDATA_WIDTH/4-1:0] m_axis_ab_tkeep,
  output logic                            m_axis_ab_tlast,
  output logic [31:0]                     beat_cnt,
  output logic                            last_err
);

  localparam int W = C_AXIS_TDATA_WIDTH;
  localparam int K = C_AXIS_TDATA_WIDTH / 8;

  typedef struct packed {
    logic         last;
    logic [K-1:0] keep;
    logic [W-1:0] data;
  } beat_t;

  beat_t       a_in;
  beat_t       b_in;
  beat_t       a_head;
  beat_t       b_head;
  logic        a_vld;
  logic        b_vld;
  logic        pair_hs;
  logic [31:0] beat_cnt_q;
  logic        last_err_q;

  assign a_in = {s_axis_a_tlast, s_axis_a_tkeep, s_axis_a_tdata};
  assign b_in = {s_axis_b_tlast, s_axis_b_tkeep, s_axis_b_tdata};

  vadd_float_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo_a (
    .ap_aclk   (ap_aclk),
    .ap_areset (ap_areset),
    .in_vld    (s_axis_a_tvalid),
    .in_rdy    (s_axis_a_tready),
    .in_dat    (a_in),
    .out_vld   (a_vld),
    .out_rdy   (pair_hs),
    .out_dat   (a_head)
  );

  vadd_float_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo_b (
    .ap_aclk   (ap_aclk),
    .ap_areset (ap_areset),
    .in_vld    (s_axis_b_tvalid),
    .in_rdy    (s_axis_b_tready),
    .in_dat    (b_in),
    .out_vld   (b_vld),
    .out_rdy   (pair_hs),
    .out_dat   (b_head)
  );

  // Output is a pure view of the two heads, so it holds still while stalled.
  assign m_axis_ab_tvalid = a_vld & b_vld;
  assign pair_hs          = m_axis_ab_tvalid & m_axis_ab_tready;
  assign m_axis_ab_tdata  = {b_head.data, a_head.data};
  assign m_axis_ab_tkeep  = {b_head.keep, a_head.keep};
  assign m_axis_ab_tlast  = a_head.last | b_head.last;
  assign beat_cnt         = beat_cnt_q;
  assign last_err         = last_err_q;

  always_ff @(posedge ap_aclk) begin
    if (ap_areset) begin
      beat_cnt_q <= '0;
      last_err_q <= 1'b0;
    end else if (pair_hs) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (a_head.last != b_head.last) last_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vadd_float_join.sv
// Scoreboard bench for vadd_float_join: directed pairing, backpressure, tlast, reset and wrap cases.
module tb_vadd_float_join;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic         last;
    logic [3:0]   keep;
    logic [W-1:0] data;
  } beat_t;

  logic          ap_aclk;
  logic          ap_areset;
  logic          s_axis_a_tvalid, s_axis_a_tready, s_axis_a_tlast;
  logic [W-1:0]  s_axis_a_tdata;
  logic [3:0]    s_axis_a_tkeep;
  logic          s_axis_b_tvalid, s_axis_b_tready, s_axis_b_tlast;
  logic [W-1:0]  s_axis_b_tdata;
  logic [3:0]    s_axis_b_tkeep;
  logic          m_axis_ab_tvalid, m_axis_ab_tready, m_axis_ab_tlast;
  logic [2*W-1:0] m_axis_ab_tdata;
  logic [7:0]    m_axis_ab_tkeep;
  logic [31:0]   beat_cnt;
  logic          last_err;

  vadd_float_join #(
    .C_AXIS_TDATA_WIDTH (W),
    .C_FIFO_DEPTH       (DEPTH)
  ) dut (
    .ap_aclk          (ap_aclk),
    .ap_areset        (ap_areset),
    .s_axis_a_tvalid  (s_axis_a_tvalid),
    .s_axis_a_tready  (s_axis_a_tready),
    .s_axis_a_tdata   (s_axis_a_tdata),
    .s_axis_a_tkeep   (s_axis_a_tkeep),
    .s_axis_a_tlast   (s_axis_a_tlast),
    .s_axis_b_tvalid  (s_axis_b_tvalid),
    .s_axis_b_tready  (s_axis_b_tready),
    .s_axis_b_tdata   (s_axis_b_tdata),
    .s_axis_b_tkeep   (s_axis_b_tkeep),
    .s_axis_b_tlast   (s_axis_b_tlast),
    .m_axis_ab_tvalid (m_axis_ab_tvalid),
    .m_axis_ab_tready (m_axis_ab_tready),
    .m_axis_ab_tdata  (m_axis_ab_tdata),
    .m_axis_ab_tkeep  (m_axis_ab_tkeep),
    .m_axis_ab_tlast  (m_axis_ab_tlast),
    .beat_cnt         (beat_cnt),
    .last_err         (last_err)
  );

  initial ap_aclk = 1'b0;
  always #5 ap_aclk = ~ap_aclk;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t src_a[$], src_b[$];
  beat_t exp_a[$], exp_b[$];
  int    ia, ib;
  int    a_pct, b_pct, m_pct;
  logic  a_acc, b_acc;
  logic  stall_prev;
  logic [72:0] held;
  logic [31:0] exp_cnt;
  logic        exp_err;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic beat_t mk(input logic [W-1:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    return b;
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic run_cycle();
    beat_t ea, eb;
    if (a_acc) s_axis_a_tvalid = 1'b0;
    if (b_acc) s_axis_b_tvalid = 1'b0;
    if (!s_axis_a_tvalid && ia < src_a.size() && $urandom_range(99) < a_pct) begin
      s_axis_a_tvalid = 1'b1;
      {s_axis_a_tlast, s_axis_a_tkeep, s_axis_a_tdata} = src_a[ia];
    end
    if (!s_axis_b_tvalid && ib < src_b.size() && $urandom_range(99) < b_pct) begin
      s_axis_b_tvalid = 1'b1;
      {s_axis_b_tlast, s_axis_b_tkeep, s_axis_b_tdata} = src_b[ib];
    end
    m_axis_ab_tready = ($urandom_range(99) < m_pct);
    #1;
    check("beat_cnt", beat_cnt, exp_cnt);
    check("last_err", last_err, exp_err);
    check("m_tvalid", m_axis_ab_tvalid, (exp_a.size() != 0 && exp_b.size() != 0));
    check("a_tready", s_axis_a_tready, (exp_a.size() < DEPTH));
    check("b_tready", s_axis_b_tready, (exp_b.size() < DEPTH));
    if (stall_prev) check("stall_hold", {m_axis_ab_tlast, m_axis_ab_tkeep, m_axis_ab_tdata}, held);
    stall_prev = 1'b0;
    if (m_axis_ab_tvalid && exp_a.size() != 0 && exp_b.size() != 0) begin
      if (m_axis_ab_tready) begin
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        check("pair_tdata", m_axis_ab_tdata, {eb.data, ea.data});
        check("pair_tkeep", m_axis_ab_tkeep, {eb.keep, ea.keep});
        check("pair_tlast", m_axis_ab_tlast, ea.last | eb.last);
        if (ea.last != eb.last) exp_err = 1'b1;
        exp_cnt = exp_cnt + 32'd1;
      end else begin
        stall_prev = 1'b1;
        held = {m_axis_ab_tlast, m_axis_ab_tkeep, m_axis_ab_tdata};
      end
    end
    a_acc = s_axis_a_tvalid & s_axis_a_tready;
    b_acc = s_axis_b_tvalid & s_axis_b_tready;
    if (a_acc) begin exp_a.push_back(src_a[ia]); ia++; end
    if (b_acc) begin exp_b.push_back(src_b[ib]); ib++; end
    @(posedge ap_aclk);
    @(negedge ap_aclk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(ia == src_a.size() && ib == src_b.size() && exp_a.size() == 0 && exp_b.size() == 0)
           && n < budget) begin
      run_cycle();
      n++;
    end
    check(tag, (n < budget), 1'b1);
  endtask

  task automatic do_reset();
    ap_areset        = 1'b1;
    s_axis_a_tvalid  = 1'b0;
    s_axis_b_tvalid  = 1'b0;
    m_axis_ab_tready = 1'b0;
    a_acc = 1'b0;
    b_acc = 1'b0;
    stall_prev = 1'b0;
    #1;
    check("rst_m_tvalid", m_axis_ab_tvalid, 1'b0);
    check("rst_a_tready", s_axis_a_tready, 1'b0);
    check("rst_b_tready", s_axis_b_tready, 1'b0);
    @(posedge ap_aclk);
    @(negedge ap_aclk);
    #1;
    check("rst_beat_cnt", beat_cnt, 32'd0);
    check("rst_last_err", last_err, 1'b0);
    check("rst_m_tvalid2", m_axis_ab_tvalid, 1'b0);
    ap_areset = 1'b0;
    exp_a.delete(); exp_b.delete();
    src_a.delete(); src_b.delete();
    ia = 0; ib = 0;
    exp_cnt = '0;
    exp_err = 1'b0;
    #1;
    check("post_rst_a_tready", s_axis_a_tready, 1'b1);
    check("post_rst_b_tready", s_axis_b_tready, 1'b1);
    @(posedge ap_aclk);
    @(negedge ap_aclk);
  endtask

  initial begin
    ap_areset = 1'b1;
    s_axis_a_tvalid = 1'b0; s_axis_a_tdata = '0; s_axis_a_tkeep = '0; s_axis_a_tlast = 1'b0;
    s_axis_b_tvalid = 1'b0; s_axis_b_tdata = '0; s_axis_b_tkeep = '0; s_axis_b_tlast = 1'b0;
    m_axis_ab_tready = 1'b0;
    ia = 0; ib = 0; a_pct = 100; b_pct = 100; m_pct = 100;
    exp_cnt = '0; exp_err = 1'b0; held = '0;
    @(negedge ap_aclk);
    do_reset();

    // A arrives alone, then B; three ordered float pairs.
    src_a.push_back(mk(32'h3F80_0000, 4'hF, 1'b0));
    src_a.push_back(mk(32'h4000_0000, 4'hF, 1'b0));
    src_a.push_back(mk(32'h4040_0000, 4'hF, 1'b1));
    src_b.push_back(mk(32'h4080_0000, 4'hF, 1'b0));
    src_b.push_back(mk(32'h40A0_0000, 4'hF, 1'b0));
    src_b.push_back(mk(32'h40C0_0000, 4'hF, 1'b1));
    a_pct = 100; b_pct = 0; m_pct = 100;
    run_cycles(5);
    check("a_only_no_pair", m_axis_ab_tvalid, 1'b0);
    b_pct = 100;
    run_until_idle("t1_drain", 50);
    check("t1_beat_cnt", beat_cnt, 32'd3);
    check("t1_last_err", last_err, 1'b0);

    // Sink stalled: both inputs fill to DEPTH, then drain in order.
    for (int i = 0; i < 6; i++) begin
      src_a.push_back(mk(32'hA000_0000 + i, 4'h3, 1'b0));
      src_b.push_back(mk(32'hB000_0000 + i, 4'hC, 1'b0));
    end
    m_pct = 0;
    run_cycles(8);
    check("t2_a_held", exp_a.size(), DEPTH);
    check("t2_a_full_rdy", s_axis_a_tready, 1'b0);
    check("t2_b_full_rdy", s_axis_b_tready, 1'b0);
    m_pct = 100;
    run_until_idle("t2_drain", 50);
    check("t2_beat_cnt", beat_cnt, 32'd9);

    // tlast on A beat 2, on B beat 3.
    for (int i = 0; i < 3; i++) begin
      src_a.push_back(mk(32'hC000_0000 + i, 4'hF, i == 1));
      src_b.push_back(mk(32'hD000_0000 + i, 4'hF, i == 2));
    end
    run_until_idle("t3_drain", 50);
    check("t3_last_err_sticky", last_err, 1'b1);

    // Reset with 2 beats in A and 1 in B, pair held by a stalled sink.
    src_a.push_back(mk(32'hDEAD_0001, 4'h1, 1'b0));
    src_a.push_back(mk(32'hDEAD_0002, 4'h2, 1'b0));
    src_b.push_back(mk(32'hDEAD_0003, 4'h4, 1'b0));
    m_pct = 0;
    run_cycles(3);
    check("t5_pair_waiting", m_axis_ab_tvalid, 1'b1);
    do_reset();
    run_cycles(2);
    src_a.push_back(mk(32'h1234_5678, 4'h9, 1'b1));
    src_b.push_back(mk(32'h9ABC_DEF0, 4'h6, 1'b1));
    m_pct = 100;
    run_until_idle("t5_drain", 50);
    check("t5_beat_cnt", beat_cnt, 32'd1);

    // Random valid/ready on all three ports.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      src_a.push_back(mk($urandom, 4'($urandom), $urandom_range(7) == 0));
      src_b.push_back(mk($urandom, 4'($urandom), $urandom_range(7) == 0));
    end
    a_pct = 60; b_pct = 55; m_pct = 50;
    run_until_idle("t4_drain", 20000);
    check("t4_beat_cnt", beat_cnt, 32'd1000);

    // Counter wrap.
    a_pct = 100; b_pct = 100; m_pct = 100;
    force dut.beat_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.beat_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      src_a.push_back(mk(32'h5000_0000 + i, 4'hF, 1'b0));
      src_b.push_back(mk(32'h6000_0000 + i, 4'hF, 1'b0));
    end
    run_until_idle("t6_drain", 50);
    check("t6_beat_cnt_wrap", beat_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
